fp32_divider: RTL and testbench
===============================

FP32_DIVIDER -- requirements
Module: fp32_divider

Interface
REQ-001 Parameter ROUND_RNE, default 1, 1 = round-to-nearest-even, 0 = truncate toward zero.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 a  input  32  IEEE-754 single dividend, captured on accepted start.
REQ-006 b  input  32  IEEE-754 single divisor, captured on accepted start.
REQ-007 result  output  32  quotient a/b; held from done until the next accepted start.
REQ-008 done  output  1  one-cycle pulse; result and flags valid.
REQ-009 busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-010 ovf  output  1  overflow flag, valid with done, held with result.
REQ-011 dz  output  1  divide-by-zero flag, valid with done, held with result.
REQ-012 nv  output  1  invalid-operation flag, valid with done, held with result.

Function
REQ-013 FSM states and transitions: IDLE -> UNPACK on start; UNPACK -> DIVIDE; DIVIDE -> ROUND after 26 iterations; ROUND -> DONE; DONE -> IDLE.
REQ-014 Fixed latency for every operand class: start sampled at edge N, done=1 during the cycle after edge N+29; no early exit for special cases.
REQ-015 start while busy=1 is ignored and does not disturb the operation in progress.
REQ-016 start asserted in the done cycle is ignored; the earliest acceptance is the following IDLE cycle.
REQ-017 UNPACK: sign = a[31] ^ b[31]; exponent = ea - eb + 127, computed 10-bit signed; mantissas get the hidden 1 prepended (24 bits).
REQ-018 Denormal inputs (exp=0, frac!=0) are treated as signed zero; denormal results are never produced.
REQ-019 DIVIDE: restoring division, one quotient bit per cycle, 26 bits total; remainder kept 25 bits wide.
REQ-020 Normalization when q[25]=0: shift left 1 and decrement exponent.
REQ-021 Rounding inputs: guard = first bit below the 23-bit fraction; sticky = OR of lower quotient bits and (remainder != 0).
REQ-022 Rounding: RNE applied when ROUND_RNE=1; a mantissa carry-out renormalizes and increments the exponent.
REQ-023 Final exponent >= 255 -> signed infinity, ovf=1.
REQ-024 Final exponent <= 0 -> signed zero, no flag.
REQ-025 Special cases, checked in priority order:
  - a or b NaN -> 32'h7FC00000, nv=1.
  - 0/0 or inf/inf -> 32'h7FC00000, nv=1.
  - finite nonzero / 0 -> signed infinity, dz=1.
  - inf/finite -> signed infinity.
  - finite/inf or 0/nonzero -> signed zero.
REQ-026 Flags are mutually exclusive; all clear for a normal result.

Reset
REQ-027 rst=0 immediately forces: FSM IDLE, result=0, done=0, busy=0, ovf=0, dz=0, nv=0, internal quotient/remainder/counter cleared.
REQ-028 Reset mid-operation aborts it; no done pulse is produced for the aborted operation.
REQ-029 First start is accepted on the first rising edge with rst=1.

Structure
REQ-030 Shared package fp32_pkg holds:
  - EXP_BIAS=127, QNAN=32'h7FC00000, DIV_ITER=26;
  - FSM state encoding;
  - operand-class encoding (zero, normal, inf, nan).
REQ-031 Sub-module fp32_div_iter: mantissa restoring-division datapath (load, step, remainder/quotient registers, iteration counter, last-iteration flag); fp32_divider holds the FSM, unpack, special-case logic, normalize/round and output registers.

Verification
REQ-032 a=32'h7F7FFFFF, b=32'h7F7FFFFF -> result=32'h3F800000, all flags 0, done 30 cycles after start.
REQ-033 a=32'h40C00000 (6.0), b=32'h40000000 (2.0) -> 32'h40400000; a=32'h3F800000, b=32'h40400000 -> 32'h3EAAAAAB (RNE), 32'h3EAAAAAA (ROUND_RNE=0).
REQ-034 a=32'h7F7FFFFF, b=32'h00800000 -> 32'h7F800000, ovf=1; a=32'h00800000, b=32'h7F7FFFFF -> 32'h00000000, no flag.
REQ-035 a=32'hBF800000, b=32'h00000000 -> 32'hFF800000, dz=1; a=b=32'h00000000 -> 32'h7FC00000, nv=1; a=32'h7FC00001 -> 32'h7FC00000, nv=1.
REQ-036 start issued, rst pulled low 10 cycles later, released, new start with 6.0/2.0 -> no done for the first operation; exactly one done with 32'h40400000.
REQ-037 start held high continuously for 100 cycles with fixed operands -> done pulses every 31 cycles, busy low for exactly one cycle between operations.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared definitions for the single-precision divider: constants, FSM states,
// operand classes and the flag bundle reported with every result.
package fp32_pkg;

    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam int          DIV_ITER = 26;
    localparam int          CNT_W    = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_ROUND,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    typedef struct packed {
        logic ovf;
        logic dz;
        logic nv;
    } flags_t;

    // Denormals fall into CLS_ZERO: the divider flushes them to signed zero.
    function automatic fp_class_e classify(input logic [31:0] x);
        if (x[30:23] == 8'h00) return CLS_ZERO;
        if (x[30:23] != 8'hFF) return CLS_NORMAL;
        return (x[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    endfunction

endpackage

// File: rtl/fp32_div_iter.sv
// Restoring mantissa divider: one quotient bit per step, DIV_ITER steps after a
// load, then holds the quotient and remainder until the next load.
module fp32_div_iter
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [23:0] dividend_i,
    input  logic [23:0] divisor_i,
    output logic [25:0] quot_o,
    output logic        rem_nz_o,
    output logic        last_o
);

    logic [24:0]      rem_q, rem_d;
    logic [25:0]      quot_q, quot_d;
    logic [23:0]      div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [25:0]      diff;
    logic [24:0]      rem_keep;
    logic             ge;

    assign last_o   = (cnt_q == CNT_W'(DIV_ITER));
    assign quot_o   = quot_q;
    assign rem_nz_o = (rem_q != '0);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        rem_d    = rem_q;
        quot_d   = quot_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        diff     = {1'b0, rem_q} - {2'b00, div_q};
        ge       = ~diff[25];
        rem_keep = ge ? diff[24:0] : rem_q;
        if (load_i) begin
            rem_d  = {1'b0, dividend_i};
            quot_d = '0;
            div_d  = divisor_i;
            cnt_d  = '0;
        end else if (step_i && !last_o) begin
            rem_d  = rem_keep << 1;
            quot_d = {quot_q[24:0], ge};
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/fp32_divider.sv
// IEEE-754 single-precision divider, fixed 30-cycle latency from accepted start
// to done, with RNE or truncating rounding and ovf/dz/nv flags.
module fp32_divider
    import fp32_pkg::*;
#(
    parameter bit ROUND_RNE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        ovf,
    output logic        dz,
    output logic        nv
);

    state_e             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               spec_q, spec_d;
    logic [31:0]        spec_res_q, spec_res_d;
    flags_t             spec_flags_q, spec_flags_d;
    logic [31:0]        result_q, result_d;
    flags_t             flags_q, flags_d;

    logic               iter_load, iter_step, iter_last, iter_rem_nz;
    logic [25:0]        iter_quot;

    fp_class_e          cls_a, cls_b;
    logic               sp_hit;
    logic [31:0]        sp_res;
    flags_t             sp_flags;
    logic signed [9:0]  unpack_exp;

    logic               norm, guard, sticky, round_up;
    logic [23:0]        mant;
    logic [24:0]        mant_r;
    logic [22:0]        frac;
    logic signed [9:0]  exp_n, exp_r;
    logic [31:0]        rnd_res;
    flags_t             rnd_flags;

    fp32_div_iter u_iter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (iter_load),
        .step_i     (iter_step),
        .dividend_i ({1'b1, a_q[22:0]}),
        .divisor_i  ({1'b1, b_q[22:0]}),
        .quot_o     (iter_quot),
        .rem_nz_o   (iter_rem_nz),
        .last_o     (iter_last)
    );

    assign unpack_exp = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
                      + 10'(EXP_BIAS);

    always_comb begin
        cls_a    = classify(a_q);
        cls_b    = classify(b_q);
        sp_hit   = 1'b1;
        sp_res   = '0;
        sp_flags = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            sp_res      = QNAN;
            sp_flags.nv = 1'b1;
        end else if ((cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
                     (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
            sp_res      = QNAN;
            sp_flags.nv = 1'b1;
        end else if (cls_a == CLS_NORMAL && cls_b == CLS_ZERO) begin
            sp_res      = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
            sp_flags.dz = 1'b1;
        end else if (cls_a == CLS_INF) begin
            sp_res = {a_q[31] ^ b_q[31], 8'hFF, 23'd0};
        end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
            sp_res = {a_q[31] ^ b_q[31], 31'd0};
        end else begin
            sp_hit = 1'b0;
        end
    end

    // A quotient below 1.0 has its leading one at bit 24 and needs one left shift.
    always_comb begin
        norm      = iter_quot[25];
        mant      = norm ? iter_quot[25:2] : iter_quot[24:1];
        guard     = norm ? iter_quot[1] : iter_quot[0];
        sticky    = (norm & iter_quot[0]) | iter_rem_nz;
        exp_n     = norm ? exp_q : exp_q - 10'sd1;
        round_up  = ROUND_RNE && guard && (sticky || mant[0]);
        mant_r    = {1'b0, mant} + {24'd0, round_up};
        exp_r     = mant_r[24] ? exp_n + 10'sd1 : exp_n;
        frac      = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        rnd_flags = '0;
        if (exp_r >= 10'sd255) begin
            rnd_res       = {sign_q, 8'hFF, 23'd0};
            rnd_flags.ovf = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            rnd_res = {sign_q, 31'd0};
        end else begin
            rnd_res = {sign_q, exp_r[7:0], frac};
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        spec_d       = spec_q;
        spec_res_d   = spec_res_q;
        spec_flags_d = spec_flags_q;
        result_d     = result_q;
        flags_d      = flags_q;
        iter_load    = 1'b0;
        iter_step    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sign_d       = a_q[31] ^ b_q[31];
                exp_d        = unpack_exp;
                spec_d       = sp_hit;
                spec_res_d   = sp_res;
                spec_flags_d = sp_flags;
                iter_load    = 1'b1;
                state_d      = S_DIVIDE;
            end
            S_DIVIDE: begin
                iter_step = 1'b1;
                if (iter_last) state_d = S_ROUND;
            end
            S_ROUND: begin
                result_d = spec_q ? spec_res_q : rnd_res;
                flags_d  = spec_q ? spec_flags_q : rnd_flags;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            spec_q       <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            spec_q       <= spec_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end

    assign result = result_q;
    assign done   = (state_q == S_DONE);
    assign busy   = (state_q != S_IDLE);
    assign ovf    = flags_q.ovf;
    assign dz     = flags_q.dz;
    assign nv     = flags_q.nv;

endmodule

// File: tb/tb_fp32_divider.sv
// Self-checking bench: directed corner cases, randomized operands against an
// exact-arithmetic reference, reset abort and back-to-back start behaviour.
module tb_fp32_divider;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b;
    logic [31:0] res_n, res_t;
    logic        done_n, busy_n, ovf_n, dz_n, nv_n;
    logic        done_t, busy_t, ovf_t, dz_t, nv_t;
    int          n_checks = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    fp32_divider #(.ROUND_RNE(1'b1)) dut_rne (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .result(res_n),
        .done(done_n), .busy(busy_n), .ovf(ovf_n), .dz(dz_n), .nv(nv_n)
    );

    fp32_divider #(.ROUND_RNE(1'b0)) dut_trunc (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .result(res_t),
        .done(done_t), .busy(busy_t), .ovf(ovf_t), .dz(dz_t), .nv(nv_t)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact quotient via wide integer division; returns {result, ovf, dz, nv}.
    function automatic logic [34:0] ref_div(input logic [31:0] x, input logic [31:0] y, input bit rne);
        logic s, zx, zy, ix, iy, nx, ny, guard, sticky;
        int ex, ey, e, sh;
        longint unsigned ma, mb, num, q, r, mant;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 23'd0);
        iy = (ey == 255) && (y[22:0] == 23'd0);
        nx = (ex == 255) && (x[22:0] != 23'd0);
        ny = (ey == 255) && (y[22:0] != 23'd0);
        if (nx || ny) return {32'h7FC00000, 3'b001};
        if ((zx && zy) || (ix && iy)) return {32'h7FC00000, 3'b001};
        if (zy && !ix) return {s, 8'hFF, 23'd0, 3'b010};
        if (ix) return {s, 8'hFF, 23'd0, 3'b000};
        if (zx || iy) return {s, 31'd0, 3'b000};
        ma  = {40'd0, 1'b1, x[22:0]};
        mb  = {40'd0, 1'b1, y[22:0]};
        num = ma << 38;
        q   = num / mb;
        r   = num % mb;
        e   = ex - ey + 127;
        if (q >= (64'd1 << 38)) sh = 15;
        else begin
            sh = 14;
            e  = e - 1;
        end
        mant   = q >> sh;
        guard  = q[sh-1];
        sticky = ((q & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0) || (r != 64'd0);
        if (rne && guard && (sticky || mant[0])) mant = mant + 64'd1;
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 3'b100};
        if (e <= 0) return {s, 31'd0, 3'b000};
        return {s, 8'(e), mant[22:0], 3'b000};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int kind;
        v    = $urandom;
        kind = $urandom_range(0, 11);
        case (kind)
            0:       v[30:23] = 8'h00;
            1:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2:       begin v[30:23] = 8'hFF; v[0] = 1'b1; end
            3, 4, 5: v[30:23] = 8'($urandom_range(100, 154));
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    // Runs one operation from IDLE; optional noise toggles start/a/b while busy.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit noise,
                          output logic [31:0] rn, output logic [31:0] rt,
                          output logic [2:0] fn, output logic [2:0] ft);
        int lat;
        lat = 0;
        rn  = '0;
        rt  = '0;
        fn  = '0;
        ft  = '0;
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) check("busy_after_start", 32'(busy_n), 32'd1);
            if (done_n) begin
                lat = k;
                rn  = res_n;
                rt  = res_t;
                fn  = {ovf_n, dz_n, nv_n};
                ft  = {ovf_t, dz_t, nv_t};
                check("busy_in_done", 32'(busy_n), 32'd1);
                check("done_both", 32'(done_t), 32'd1);
            end else if (noise && k < 25) begin
                start = 1'($urandom);
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'd30);
        @(negedge clk);
        check("done_one_cycle", 32'({done_n, busy_n}), 32'd0);
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rne;
        logic [31:0] tz;
        logic [2:0]  fl;
    } vec_t;

    localparam int NVEC = 13;
    localparam vec_t VECS [NVEC] = '{
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000, 3'b000},
        '{32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 3'b000},
        '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 3'b000},
        '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 32'h7F800000, 3'b100},
        '{32'h00800000, 32'h7F7FFFFF, 32'h00000000, 32'h00000000, 3'b000},
        '{32'hBF800000, 32'h00000000, 32'hFF800000, 32'hFF800000, 3'b010},
        '{32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 3'b001},
        '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 3'b001},
        '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 3'b001},
        '{32'hFF800000, 32'h40000000, 32'hFF800000, 32'hFF800000, 3'b000},
        '{32'h40000000, 32'hFF800000, 32'h80000000, 32'h80000000, 3'b000},
        '{32'h00000001, 32'h3F800000, 32'h00000000, 32'h00000000, 3'b000},
        '{32'h3F800000, 32'h80000001, 32'hFF800000, 32'hFF800000, 3'b010}
    };

    initial begin
        logic [31:0] rn, rt;
        logic [2:0]  fn, ft;
        logic [34:0] en, et;
        logic [31:0] x, y, got_res;
        int          ndone, lat;
        int          dq[$];
        int          lq[$];

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check("rst_result", res_n, 32'd0);
        check("rst_ctrl", 32'({done_n, busy_n, ovf_n, dz_n, nv_n}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_op(VECS[i].a, VECS[i].b, 1'b0, rn, rt, fn, ft);
            check($sformatf("dir%0d_rne", i), rn, VECS[i].rne);
            check($sformatf("dir%0d_trunc", i), rt, VECS[i].tz);
            check($sformatf("dir%0d_flags", i), 32'(fn), 32'(VECS[i].fl));
            check($sformatf("dir%0d_tflags", i), 32'(ft), 32'(VECS[i].fl));
        end

        for (int i = 0; i < 150; i++) begin
            x  = rand_fp();
            y  = rand_fp();
            en = ref_div(x, y, 1'b1);
            et = ref_div(x, y, 1'b0);
            run_op(x, y, ($urandom_range(0, 3) == 0), rn, rt, fn, ft);
            check($sformatf("rnd_rne %h/%h", x, y), rn, en[34:3]);
            check($sformatf("rnd_trunc %h/%h", x, y), rt, et[34:3]);
            check($sformatf("rnd_flags %h/%h", x, y), 32'({fn, ft}), 32'({en[2:0], et[2:0]}));
        end

        @(negedge clk);
        a     = 32'h7F7FFFFF;
        b     = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ctrl", 32'({done_n, busy_n, ovf_n, dz_n, nv_n}), 32'd0);
        check("abort_result", res_n, 32'd0);
        @(negedge clk);
        rst     = 1'b1;
        a       = 32'h40C00000;
        b       = 32'h40000000;
        start   = 1'b1;
        ndone   = 0;
        lat     = 0;
        got_res = '0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done_n) begin
                ndone++;
                lat     = k;
                got_res = res_n;
            end
        end
        check("abort_ndone", 32'(ndone), 32'd1);
        check("abort_latency", 32'(lat), 32'd30);
        check("abort_result_new", got_res, 32'h40400000);

        @(negedge clk);
        a     = 32'h3F800000;
        b     = 32'h40400000;
        start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done_n) begin
                dq.push_back(k);
                check("stream_res", res_n, 32'h3EAAAAAB);
            end
            if (!busy_n) lq.push_back(k);
        end
        start = 1'b0;
        check("stream_ndone", 32'(dq.size()), 32'd3);
        foreach (dq[i]) check($sformatf("stream_done_at%0d", i), 32'(dq[i]), 32'(30 + 31 * i));
        check("stream_nlow", 32'(lq.size()), 32'd3);
        foreach (lq[i]) check($sformatf("stream_low_at%0d", i), 32'(lq[i]), 32'(31 + 31 * i));
        for (int k = 0; k < 80 && busy_n; k++) @(negedge clk);
        check("drain_idle", 32'(busy_n), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
